// File: rtl/dir_lut_arb.sv
// Round-robin arbiter that shares one combinational direction LUT among N_REQ requesters.
// Optional per-requester saturating grant counters are built when DIR_LUT_ARB_STATS_EN is defined.
module dir_lut_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int AW    = 8,
    parameter int DW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_addr,
    output logic [N_REQ-1:0]      req_ready,
    output logic [AW-1:0]         lut_a,
    input  logic [DW-1:0]         lut_spo,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic                  busy,
    input  logic [ID_W-1:0]       stat_sel,
    output logic [15:0]           stat_cnt
);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    // Explicit compare so non-power-of-two N_REQ wraps correctly.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (v == LAST_ID) ? '0 : v + ID_W'(1);
    endfunction

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  scan;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic [N_REQ-1:0] gnt_vec;

    logic             vld_p1;
    logic [ID_W-1:0]  id_p1;
    logic [AW-1:0]    addr_p1;
    logic             vld_p2;
    logic [ID_W-1:0]  id_p2;
    logic [DW-1:0]    data_p2;

    // Stage 0: pick the first valid requester at or after the pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        gnt_vec = '0;
        scan    = rr_ptr;
        if (en && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt_any && req_valid[scan]) begin
                    gnt_any = 1'b1;
                    gnt_id  = scan;
                end
                scan = wrap_inc(scan);
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_id] = 1'b1;
        end
    end

    assign req_ready = gnt_vec;

    // Stage 1: the registered address drives the shared LUT directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            addr_p1 <= '0;
        end else begin
            vld_p1 <= gnt_any;
            if (gnt_any) begin
                rr_ptr  <= wrap_inc(gnt_id);
                id_p1   <= gnt_id;
                addr_p1 <= req_addr[gnt_id*AW +: AW];
            end
        end
    end

    assign lut_a = addr_p1;

    // Stage 2: capture the LUT result; id and data hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            id_p2   <= '0;
            data_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                id_p2   <= id_p1;
                data_p2 <= lut_spo;
            end
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_id    = id_p2;
    assign rsp_data  = data_p2;
    assign busy      = vld_p1 | vld_p2;

`ifdef DIR_LUT_ARB_STATS_EN
    logic [15:0] grant_cnt [N_REQ];
    logic [15:0] stat_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
            stat_q <= '0;
        end else begin
            if (gnt_any) begin
                grant_cnt[gnt_id] <= sat_inc(grant_cnt[gnt_id]);
            end
            stat_q <= grant_cnt[stat_sel];
        end
    end

    assign stat_cnt = stat_q;
`else
    logic stat_sel_unused;
    assign stat_sel_unused = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_dir_lut_arb.sv
// Bench for dir_lut_arb: cycle-level reference model plus directed vectors with literal expectations.
// Define DIR_LUT_ARB_STATS_EN to also exercise the grant counters.
module tb_dir_lut_arb;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int AW    = 8;
    localparam int DW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ-1:0]    req_ready;
    logic [AW-1:0]       lut_a;
    logic [DW-1:0]       lut_spo;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                busy;
    logic [ID_W-1:0]     stat_sel;
    logic [15:0]         stat_cnt;
    logic [AW-1:0]       addr [N_REQ];

    always #5 clk = ~clk;

    assign req_addr = {addr[3], addr[2], addr[1], addr[0]};
    assign lut_spo  = lut_a[4:0] ^ 5'h15;

    dir_lut_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .lut_a(lut_a), .lut_spo(lut_spo), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .stat_sel(stat_sel),
        .stat_cnt(stat_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pointer, list of responses due at a given cycle, last-held values.
    typedef struct { int due; int id; int data; } rsp_t;
    rsp_t q[$];
    int   m        = 0;
    int   ptr      = 0;
    int   lh_addr  = 0;
    int   lh_id    = 0;
    int   lh_data  = 0;
    int   exp_stat = 0;
    int   cnt_m [N_REQ];
    int   g;
    int   cand;
    bit   exp_rv;
    bit   exp_busy;
    int   exp_ready;

    initial begin
        for (int i = 0; i < N_REQ; i++) cnt_m[i] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            m++;
            exp_rv = 1'b0;
            if (q.size() > 0 && q[0].due == m) begin
                exp_rv  = 1'b1;
                lh_id   = q[0].id;
                lh_data = q[0].data;
                q.delete(0);
            end
            exp_busy = exp_rv || (q.size() > 0 && q[0].due == m + 1);
            g = -1;
            if (!rst && en) begin
                for (int k = 0; k < N_REQ; k++) begin
                    cand = (ptr + k) % N_REQ;
                    if (g < 0 && req_valid[cand]) g = cand;
                end
            end
            exp_ready = (g >= 0) ? (1 << g) : 0;

            chk("model_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("model_lut_a",     32'(lut_a),     32'(lh_addr));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("model_rsp_id",    32'(rsp_id),    32'(lh_id));
            chk("model_rsp_data",  32'(rsp_data),  32'(lh_data));
            chk("model_busy",      32'(busy),      32'(exp_busy));
            chk("model_stat_cnt",  32'(stat_cnt),  32'(exp_stat));

            if (rst) begin
                q.delete();
                ptr = 0; lh_addr = 0; lh_id = 0; lh_data = 0; exp_stat = 0;
                for (int i = 0; i < N_REQ; i++) cnt_m[i] = 0;
            end else begin
`ifdef DIR_LUT_ARB_STATS_EN
                exp_stat = cnt_m[stat_sel];
`endif
                if (g >= 0) begin
                    ptr = (g + 1) % N_REQ;
                    q.push_back('{m + 2, g, int'(addr[g][4:0] ^ 5'h15)});
                    lh_addr = int'(addr[g]);
                    if (cnt_m[g] < 65535) cnt_m[g]++;
                end
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge, then return at the falling edge.
    task automatic cyc(input logic [3:0] v, input logic e, input logic r);
        @(posedge clk);
        #1;
        req_valid = v;
        en        = e;
        rst       = r;
        @(negedge clk);
    endtask

    logic [4:0] exp_stream [4];

    initial begin
        exp_stream = '{5'h15, 5'h14, 5'h17, 5'h16};
        rst = 1'b1; en = 1'b0; req_valid = '0; stat_sel = '0;
        addr[0] = 8'h00; addr[1] = 8'h3A; addr[2] = 8'h02; addr[3] = 8'h03;
        @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_busy",      32'(busy),      32'h0);

        // Single request from requester 1.
        cyc(4'b0010, 1'b1, 1'b0);
        chk("single_ready", 32'(req_ready), 32'h2);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("single_s1_busy", 32'(busy), 32'h1);
        chk("single_lut_a",   32'(lut_a), 32'h3A);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id",    32'(rsp_id),    32'h1);
        chk("single_rsp_data",  32'(rsp_data),  32'h0F);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("single_pulse_end", 32'(rsp_valid), 32'h0);
        chk("single_idle",      32'(busy),      32'h0);

        // Pointer is at 2: lower requesters still win via wrap.
        cyc(4'b0001, 1'b1, 1'b0);
        chk("wrap_grant0", 32'(req_ready), 32'h1);
        cyc(4'b0011, 1'b1, 1'b0);
        chk("wrap_grant1", 32'(req_ready), 32'h2);
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);

        // Grant requester 3 to park the pointer at 0, then all four held valid.
        @(posedge clk);
        #1;
        addr[1] = 8'h01; req_valid = 4'b1000; en = 1'b1;
        @(negedge clk);
        chk("park_grant3", 32'(req_ready), 32'h8);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b1111, 1'b1, 1'b0);
            chk("stream_ready", 32'(req_ready), 32'(1 << (i % 4)));
            if (i >= 2) begin
                chk("stream_rsp_valid", 32'(rsp_valid), 32'h1);
                chk("stream_rsp_data",  32'(rsp_data),  32'(exp_stream[(i - 2) % 4]));
            end
        end

        // en dropped with requests pending: in-flight work drains, pointer preserved.
        cyc(4'b1111, 1'b1, 1'b0);
        chk("en_grant0", 32'(req_ready), 32'h1);
        cyc(4'b1111, 1'b1, 1'b0);
        chk("en_grant1", 32'(req_ready), 32'h2);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("en_off_ready",  32'(req_ready), 32'h0);
        chk("en_off_rsp_id0", 32'(rsp_id),   32'h0);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("en_off_rsp_v",  32'(rsp_valid), 32'h1);
        chk("en_off_rsp_id1", 32'(rsp_id),   32'h1);
        cyc(4'b1111, 1'b0, 1'b0);
        chk("en_off_drained", 32'(busy), 32'h0);
        cyc(4'b1111, 1'b1, 1'b0);
        chk("en_resume_grant2", 32'(req_ready), 32'h4);

        // Reset with two lookups in flight.
        cyc(4'b1111, 1'b1, 1'b0);
        chk("pre_rst_grant3", 32'(req_ready), 32'h8);
        cyc(4'b1111, 1'b1, 1'b1);
        chk("rst_ready",  32'(req_ready), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id),    32'h2);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post_rst_busy",      32'(busy),      32'h0);
        chk("post_rst_lut_a",     32'(lut_a),     32'h0);
        chk("post_rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("post_rst_rsp_data",  32'(rsp_data),  32'h0);
        cyc(4'b1111, 1'b1, 1'b0);
        chk("post_rst_first_grant", 32'(req_ready), 32'h1);
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("post_rst_rsp", 32'(rsp_data), 32'h15);
        cyc(4'b0000, 1'b1, 1'b0);

`ifdef DIR_LUT_ARB_STATS_EN
        cyc(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(4'b1000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 4'b0000; stat_sel = 2'd3;
        @(negedge clk);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("stat_five", 32'(stat_cnt), 32'd5);
        for (int i = 0; i < 65540; i++) cyc(4'b1000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("stat_saturate", 32'(stat_cnt), 32'hFFFF);
`else
        chk("stat_tied_zero", 32'(stat_cnt), 32'h0);
`endif

        cyc(4'b0000, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
